// File: rtl/alu_op_sequencer.sv
// Command FIFO plus IDLE/RUN/RESP sequencer driving a start/done ALU and returning tagged results.
// Optional watchdog on ALU completion is compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_a,
  input  logic [DATA_W-1:0]     cmd_b,
  input  logic [2:0]            cmd_op,
  input  logic [TAG_W-1:0]      cmd_tag,
  output logic                  alu_start,
  output logic [2:0]            alu_op,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic                  alu_done,
  input  logic [2*DATA_W-1:0]   alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic                  rsp_error,
  output logic                  busy,
  output logic [15:0]           rsp_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RES_W = 2 * DATA_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("alu_op_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

  // FIFO storage
  logic [DATA_W-1:0] a_mem   [DEPTH];
  logic [DATA_W-1:0] b_mem   [DEPTH];
  logic [2:0]        op_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  state_t            state_q, state_d;
  logic              alu_start_q, alu_start_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [TAG_W-1:0]  inflight_tag_q, inflight_tag_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
  logic              rsp_error_q, rsp_error_d;
  logic [15:0]       rsp_count_q, rsp_count_d;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  logic push, pop;
  logic [DATA_W-1:0] head_a, head_b;
  logic [2:0]        head_op;
  logic [TAG_W-1:0]  head_tag;

  // Full check uses only the registered count, so a pop never frees a slot in the same cycle.
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  assign head_a   = a_mem[rd_ptr_q];
  assign head_b   = b_mem[rd_ptr_q];
  assign head_op  = op_mem[rd_ptr_q];
  assign head_tag = tag_mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr_q]   <= cmd_a;
      b_mem[wr_ptr_q]   <= cmd_b;
      op_mem[wr_ptr_q]  <= cmd_op;
      tag_mem[wr_ptr_q] <= cmd_tag;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    alu_start_d    = alu_start_q;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    inflight_tag_d = inflight_tag_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_tag_d      = rsp_tag_q;
    rsp_error_d    = rsp_error_q;
    rsp_count_d    = rsp_count_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    wd_d           = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0 && !rsp_valid_q) begin
          pop            = 1'b1;
          inflight_tag_d = head_tag;
          if (head_op > 3'd4) begin
            // Illegal opcode is answered directly without touching the ALU.
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_error_d  = 1'b1;
            rsp_tag_d    = head_tag;
            state_d      = S_RESP;
          end else begin
            alu_a_d     = head_a;
            alu_b_d     = head_b;
            alu_op_d    = head_op;
            alu_start_d = 1'b1;
            state_d     = S_RUN;
`ifdef ALU_SEQ_TIMEOUT_EN
            wd_d        = '0;
`endif
          end
        end
      end
      S_RUN: begin
        if (alu_op_q == 3'd0) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '0;
          rsp_error_d  = 1'b0;
          rsp_tag_d    = inflight_tag_q;
          state_d      = S_RESP;
        end else if (alu_done) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_result;
          rsp_error_d  = 1'b0;
          rsp_tag_d    = inflight_tag_q;
          state_d      = S_RESP;
        end
`ifdef ALU_SEQ_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          alu_start_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_result_d = '1;
          rsp_error_d  = 1'b1;
          rsp_tag_d    = inflight_tag_q;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_count_d = rsp_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= S_IDLE;
      alu_start_q    <= 1'b0;
      alu_op_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      inflight_tag_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_tag_q      <= '0;
      rsp_error_q    <= 1'b0;
      rsp_count_q    <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
      wd_q           <= '0;
`endif
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      alu_start_q    <= alu_start_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_error_q    <= rsp_error_d;
      rsp_count_q    <= rsp_count_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      wd_q           <= wd_d;
`endif
    end
  end

  assign alu_start  = alu_start_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_count  = rsp_count_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE) || rsp_valid_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer; ALU handshake is driven by hand in each scenario.
module tb_alu_op_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;

  logic               clk;
  logic               reset_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [DATA_W-1:0]  cmd_a, cmd_b;
  logic [2:0]         cmd_op;
  logic [TAG_W-1:0]   cmd_tag;
  logic               alu_start;
  logic [2:0]         alu_op;
  logic [DATA_W-1:0]  alu_a, alu_b;
  logic               alu_done;
  logic [2*DATA_W-1:0] alu_result;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2*DATA_W-1:0] rsp_result;
  logic [TAG_W-1:0]   rsp_tag;
  logic               rsp_error;
  logic               busy;
  logic [15:0]        rsp_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_tag   (rsp_tag),
    .rsp_error (rsp_error),
    .busy      (busy),
    .rsp_count (rsp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    cmd_a = 8'h11; cmd_b = 8'h22; cmd_op = 3'd1; cmd_tag = 4'd1;
    tick();
    tick();
    n_checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_error !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: start=%b valid=%b err=%b busy=%b required 0 0 0 0",
               alu_start, rsp_valid, rsp_error, busy);
    end
    n_checks++;
    if (alu_op !== 3'd0 || alu_a !== 8'd0 || alu_b !== 8'd0 || rsp_result !== 16'd0 ||
        rsp_tag !== 4'd0 || rsp_count !== 16'd0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_data: op=%0d a=%h b=%h res=%h tag=%0d cnt=%0d ready=%b required zeros, ready=1",
               alu_op, alu_a, alu_b, rsp_result, rsp_tag, rsp_count, cmd_ready);
    end
    cmd_valid = 1'b0;
    reset_n   = 1'b1;
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b0 || alu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_push: busy=%b start=%b required 0 0", busy, alu_start);
    end
    $display("reset: released, busy=%b cmd_ready=%b", busy, cmd_ready);
  endtask

  task automatic test_add();
    int hi;
    push(8'hFF, 8'h01, 3'd1, 4'd3);
    n_checks++;
    if (alu_start !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_push: start=%b busy=%b required 0 1", alu_start, busy);
    end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (alu_start === 1'b1) hi++;
    end
    n_checks++;
    if (hi !== 4 || alu_a !== 8'hFF || alu_b !== 8'h01 || alu_op !== 3'd1) begin
      n_fail++;
      $display("FAIL add_issue: start_cycles=%0d a=%h b=%h op=%0d required 4 ff 01 1",
               hi, alu_a, alu_b, alu_op);
    end
    alu_done = 1'b1; alu_result = 16'h0100;
    tick();
    alu_done = 1'b0;
    n_checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 16'h0100 ||
        rsp_tag !== 4'd3 || rsp_error !== 1'b0 || rsp_count !== 16'd0) begin
      n_fail++;
      $display("FAIL add_rsp: start=%b valid=%b res=%h tag=%0d err=%b cnt=%0d required 0 1 0100 3 0 0",
               alu_start, rsp_valid, rsp_result, rsp_tag, rsp_error, rsp_count);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_count !== 16'd1) begin
      n_fail++;
      $display("FAIL add_handshake: valid=%b cnt=%0d required 0 1", rsp_valid, rsp_count);
    end
    $display("add: result=%h tag=%0d rsp_count=%0d", rsp_result, rsp_tag, rsp_count);
  endtask

  task automatic test_back_to_back();
    push(8'hFF, 8'hFF, 3'd4, 4'd5);
    push(8'h01, 8'h02, 3'd1, 4'd6);
    n_checks++;
    if (alu_start !== 1'b1 || alu_op !== 3'd4) begin
      n_fail++;
      $display("FAIL mul_issue: start=%b op=%0d required 1 4", alu_start, alu_op);
    end
    tick();
    alu_done = 1'b1; alu_result = 16'hFE01;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 16'hFE01 || rsp_tag !== 4'd5 ||
          rsp_error !== 1'b0 || alu_start !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_hold[%0d]: valid=%b res=%h tag=%0d err=%b start=%b required 1 fe01 5 0 0",
                 i, rsp_valid, rsp_result, rsp_tag, rsp_error, alu_start);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: start=%b valid=%b required 0 0", alu_start, rsp_valid);
    end
    tick();
    n_checks++;
    if (alu_start !== 1'b1 || alu_a !== 8'h01 || alu_b !== 8'h02 || alu_op !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_issue: start=%b a=%h b=%h op=%0d required 1 01 02 1",
               alu_start, alu_a, alu_b, alu_op);
    end
    alu_done = 1'b1; alu_result = 16'h0003;
    tick();
    alu_done = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0003 || rsp_tag !== 4'd6) begin
      n_fail++;
      $display("FAIL b2b_rsp: valid=%b res=%h tag=%0d required 1 0003 6", rsp_valid, rsp_result, rsp_tag);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_count !== 16'd3) begin
      n_fail++;
      $display("FAIL b2b_count: cnt=%0d required 3", rsp_count);
    end
    $display("back_to_back: mul held 5 cycles, rsp_count=%0d", rsp_count);
  endtask

  task automatic test_full_fifo();
    int accepted;
    int waited;
    accepted  = 0;
    cmd_valid = 1'b1;
    cmd_b     = 8'h00;
    cmd_op    = 3'd1;
    for (int c = 0; c < 8; c++) begin
      cmd_tag = 4'(accepted);
      cmd_a   = 8'(accepted);
      if (cmd_ready === 1'b1) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (accepted !== 5 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_accepts: accepted=%0d ready=%b required 5 0", accepted, cmd_ready);
    end
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (alu_start !== 1'b1 && waited < 4) begin
        tick();
        waited++;
      end
      n_checks++;
      if (alu_start !== 1'b1 || alu_a !== 8'(k)) begin
        n_fail++;
        $display("FAIL full_issue[%0d]: start=%b a=%h required 1 %h", k, alu_start, alu_a, 8'(k));
      end
      alu_done = 1'b1; alu_result = 16'(k);
      tick();
      alu_done = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_tag !== 4'(k) || rsp_result !== 16'(k)) begin
        n_fail++;
        $display("FAIL full_order[%0d]: valid=%b tag=%0d res=%h required 1 %0d %h",
                 k, rsp_valid, rsp_tag, rsp_result, k, 16'(k));
      end
      $display("full_fifo: response tag=%0d", rsp_tag);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    n_checks++;
    if (rsp_count !== 16'd8 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: cnt=%0d busy=%b required 8 0", rsp_count, busy);
    end
  endtask

  task automatic test_nop_illegal();
    push(8'h12, 8'h34, 3'd0, 4'd7);
    push(8'h56, 8'h78, 3'd6, 4'd8);
    n_checks++;
    if (alu_start !== 1'b1 || alu_op !== 3'd0) begin
      n_fail++;
      $display("FAIL nop_issue: start=%b op=%0d required 1 0", alu_start, alu_op);
    end
    tick();
    n_checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 16'd0 ||
        rsp_error !== 1'b0 || rsp_tag !== 4'd7) begin
      n_fail++;
      $display("FAIL nop_rsp: start=%b valid=%b res=%h err=%b tag=%0d required 0 1 0000 0 7",
               alu_start, rsp_valid, rsp_result, rsp_error, rsp_tag);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    n_checks++;
    if (alu_start !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 16'd0 ||
        rsp_error !== 1'b1 || rsp_tag !== 4'd8) begin
      n_fail++;
      $display("FAIL illegal_rsp: start=%b valid=%b res=%h err=%b tag=%0d required 0 1 0000 1 8",
               alu_start, rsp_valid, rsp_result, rsp_error, rsp_tag);
    end
    alu_done = 1'b1; alu_result = 16'hABCD;
    tick();
    alu_done = 1'b0;
    n_checks++;
    if (rsp_result !== 16'd0 || rsp_error !== 1'b1 || alu_start !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_done: res=%h err=%b start=%b required 0000 1 0", rsp_result, rsp_error, alu_start);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_count !== 16'd10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL nop_illegal_count: cnt=%0d busy=%b required 10 0", rsp_count, busy);
    end
    $display("nop_illegal: rsp_count=%0d", rsp_count);
  endtask

`ifdef ALU_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    push(8'h0F, 8'h0F, 3'd4, 4'd9);
    hi = 0;
    tick();
    while (alu_start === 1'b1 && hi < 40) begin
      hi++;
      tick();
    end
    n_checks++;
    if (hi !== 16 || rsp_valid !== 1'b1 || rsp_result !== 16'hFFFF ||
        rsp_error !== 1'b1 || rsp_tag !== 4'd9) begin
      n_fail++;
      $display("FAIL timeout: start_cycles=%0d valid=%b res=%h err=%b tag=%0d required 16 1 ffff 1 9",
               hi, rsp_valid, rsp_result, rsp_error, rsp_tag);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    $display("timeout: start_cycles=%0d", hi);
  endtask
`endif

  task automatic test_reset_midop();
    push(8'h01, 8'h01, 3'd1, 4'd1);
    push(8'h02, 8'h02, 3'd1, 4'd2);
    push(8'h03, 8'h03, 3'd1, 4'd3);
    tick();
    n_checks++;
    if (alu_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_setup: start=%b busy=%b required 1 1", alu_start, busy);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (alu_start !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_count !== 16'd0 ||
        alu_a !== 8'd0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_async: start=%b busy=%b valid=%b cnt=%0d a=%h ready=%b required 0 0 0 0 00 1",
               alu_start, busy, rsp_valid, rsp_count, alu_a, cmd_ready);
    end
    tick();
    reset_n  = 1'b1;
    alu_done = 1'b1; alu_result = 16'h1234;
    tick();
    alu_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_start !== 1'b0) begin
        n_fail++;
        $display("FAIL midop_after[%0d]: valid=%b busy=%b start=%b required 0 0 0",
                 i, rsp_valid, busy, alu_start);
      end
    end
    $display("reset_midop: busy=%b rsp_count=%0d", busy, rsp_count);
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_op     = '0;
    cmd_tag    = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    rsp_ready  = 1'b0;
    test_reset();
    test_add();
    test_back_to_back();
    test_full_fifo();
    test_nop_illegal();
`ifdef ALU_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Parametrised command sequencer between the processor's instruction unit and a start/done-handshake ALU. It buffers operations in a command FIFO and issues them to the ALU one at a time. It holds `start` until `done` and returns each result, tagged, through a valid/ready response port. It generalises single-op ALU driving to configurable operand width, queue depth and tagged, back-pressured responses, with optional hang detection.

## Interface
Parameters:
- DATA_W, 8, operand width; result width is 2*DATA_W
- DEPTH, 4, command FIFO entries; power of two, >= 2
- TAG_W, 4, width of the caller tag carried from command to response
- TIMEOUT, 64, max cycles to wait for `alu_done` (used only when the watchdog is compiled in)

Ports:
- clk  in  1  clock; everything samples on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_a  in  DATA_W  operand A
- cmd_b  in  DATA_W  operand B
- cmd_op  in  3  opcode: 0 nop, 1 add, 2 and, 3 xor, 4 mul, 5–7 illegal
- cmd_tag  in  TAG_W  caller tag
- alu_start  out  1  ALU start
- alu_op  out  3  opcode to ALU
- alu_a  out  DATA_W  operand A to ALU
- alu_b  out  DATA_W  operand B to ALU
- alu_done  in  1  ALU completion
- alu_result  in  2*DATA_W  ALU result
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_result  out  2*DATA_W  result
- rsp_tag  out  TAG_W  tag of the completed command
- rsp_error  out  1  illegal opcode or timeout
- busy  out  1  FIFO non-empty, op in flight, or response pending
- rsp_count  out  16  completed response handshakes, wrapping

## Operation
- **Command FIFO:** writes when `cmd_valid && cmd_ready`. `cmd_ready = (count != DEPTH)`, a registered-count compare, so a full FIFO refuses pushes even in a cycle that pops. Pointers wrap modulo DEPTH.
- **FSM states: IDLE, RUN, RESP.**
- **IDLE:**
  - Pops when the FIFO is non-empty and `rsp_valid == 0`.
  - Legal op: loads `alu_a`, `alu_b` and `alu_op`, sets `alu_start = 1`, and goes to RUN.
  - Illegal op (5–7): the ALU is not started. Response is loaded with result 0 and error = 1, and the FSM goes to RESP.
- **RUN, non-nop:** `alu_start` is held high and operands are held stable. When `alu_done` is sampled high, the FSM:
  - captures `alu_result`,
  - clears `alu_start`,
  - sets `rsp_valid` with error 0,
  - goes to RESP.
- **RUN, nop:** `alu_start` is high for exactly one cycle and `alu_done` is ignored. Response has result 0 and error 0.
- **RESP:** holds `rsp_*` stable until `rsp_valid && rsp_ready`. On that handshake it clears `rsp_valid`, increments `rsp_count`, and returns to IDLE.
- **Ordering:** only one op is in flight, and responses leave strictly in command order.
- **Arithmetic:** the block never computes results. `rsp_result` is `alu_result` zero-width-adjusted to 2*DATA_W, as received.

## Timing
- **Reset values:**
  - `alu_start`, `rsp_valid`, `rsp_error`, `busy`: 0
  - `alu_op`, `alu_a`, `alu_b`, `rsp_result`, `rsp_tag`, `rsp_count`: 0
  - `cmd_ready`: 1, but no push is taken while `reset_n` is low
- **Issue latency:** a command pushed at edge N into an empty, idle block is popped at edge N+1, so `alu_start` is high from N+1.
- **Done-to-response latency:** `alu_done` sampled at edge M gives `alu_start` low and `rsp_valid` high from M.
- **Nop:** `alu_start` is high N+1..N+2 and `rsp_valid` is high from N+2.
- **Illegal op:** `rsp_valid` is high from N+1.
- **Back-to-back:** a response accepted at edge R lets IDLE pop at R+1, so there is at least one idle cycle between ops.
- **Stray `alu_done`:** ignored outside RUN.
- **Reset mid-operation:** asynchronous clear of FIFO, FSM and outputs. `alu_start` drops immediately and any in-flight result is discarded.

## Configuration
- **`ALU_SEQ_TIMEOUT_EN` defined:** a watchdog counts RUN cycles for non-nop ops. If `alu_done` has not been seen after TIMEOUT cycles, the FSM:
  - clears `alu_start`,
  - responds with result all-ones and `rsp_error = 1`,
  - goes to RESP.

  A `alu_done` arriving in the same cycle the count expires wins: normal result, error 0.
- **Not defined:** no counter is built and RUN waits indefinitely. `rsp_error` is raised only for illegal opcodes.

## Test plan
- **Add:** DATA_W=8, push add A=0xFF B=0x01 tag=3; ALU model returns 0x0100 after 3 cycles. Expect `alu_start` high 4 cycles, then `rsp_result=0x0100`, tag 3, error 0, and `rsp_count` 0→1.
- **Mul with back-pressure:** mul 0xFF×0xFF (ALU returns 0xFE01), `rsp_ready` held low 5 cycles. Expect response stable for all 5 cycles and no new `alu_start` until the handshake.
- **Full FIFO:** DEPTH=4, `alu_done` held low, push 6 commands. Expect `cmd_ready` low after 5 accepts (4 queued, 1 in flight). Responses come out in tag order 0..4.
- **Nop and illegal:** push nop then op=6. Expect a single-cycle `alu_start` with response 0 / error 0, then a response 0 / error 1 with no `alu_start`.
- **Timeout:** `ALU_SEQ_TIMEOUT_EN` defined, TIMEOUT=16, ALU never answers. Expect `alu_start` to fall after 16 cycles and a response of 0xFFFF with error 1.
- **Reset mid-op:** assert `reset_n` low mid-RUN with 2 commands queued. Expect all outputs at reset values immediately. After release, no response appears and `busy` stays 0.
